// File: rtl/wb_stage.sv
// Writeback stage of the RV32I pipeline: accepts one retiring instruction per
// handshake, waits for load data, aligns/extends it and drives the register file.
module wb_stage #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_rd,
  input  logic        m_reg_write,
  input  logic        m_is_load,
  input  logic [2:0]  m_funct3,
  input  logic [1:0]  m_addr_lo,
  input  logic [31:0] m_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd,
  output logic [31:0] reg_data3,
  output logic        reg_write,
  output logic [63:0] instret,
  output logic        load_timeout,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where m_valid && m_ready;
  // m_ready is low only while a load is outstanding, and m_valid must not
  // depend on m_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  p_rd_q, p_rd_d;
  logic        p_we_q, p_we_d;
  logic [2:0]  p_funct3_q, p_funct3_d;
  logic [1:0]  p_addr_lo_q, p_addr_lo_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        reg_write_q, reg_write_d;
  logic [63:0] instret_q, instret_d;
  logic        load_timeout_q, load_timeout_d;

  logic        accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign m_ready      = (state_q != S_WAIT);
  assign accept       = m_valid && m_ready;
  assign rd           = rd_q;
  assign reg_data3    = data_q;
  assign reg_write    = reg_write_q;
  assign instret      = instret_q;
  assign load_timeout = load_timeout_q;
  assign dbg_state    = state_q;

  // Halfword selection ignores addr_lo[0]; misaligned halves are not trapped here.
  always_comb begin
    ld_byte   = dmem_rdata[{p_addr_lo_q, 3'b000} +: 8];
    ld_half   = p_addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (p_funct3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    p_rd_d         = p_rd_q;
    p_we_d         = p_we_q;
    p_funct3_d     = p_funct3_q;
    p_addr_lo_d    = p_addr_lo_q;
    wait_cnt_d     = wait_cnt_q;
    rd_d           = rd_q;
    data_d         = data_q;
    reg_write_d    = 1'b0;
    instret_d      = instret_q;
    load_timeout_d = load_timeout_q;
    case (state_q)
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        // Data arriving on the expiry cycle still completes the load.
        if (dmem_rvalid) begin
          state_d     = S_DONE;
          rd_d        = p_rd_q;
          data_d      = load_data;
          reg_write_d = p_we_q && (p_rd_q != 5'd0);
          instret_d   = instret_q + 64'd1;
        end else if ((TIMEOUT != 8'd0) && (wait_cnt_q == TIMEOUT - 8'd1)) begin
          state_d        = S_IDLE;
          load_timeout_d = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          p_rd_d      = m_rd;
          p_we_d      = m_reg_write;
          p_funct3_d  = m_funct3;
          p_addr_lo_d = m_addr_lo;
          if (m_is_load) begin
            state_d    = S_WAIT;
            wait_cnt_d = 8'd0;
          end else begin
            state_d     = S_DONE;
            rd_d        = m_rd;
            data_d      = m_result;
            reg_write_d = m_reg_write && (m_rd != 5'd0);
            instret_d   = instret_q + 64'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      p_rd_q         <= 5'd0;
      p_we_q         <= 1'b0;
      p_funct3_q     <= 3'd0;
      p_addr_lo_q    <= 2'd0;
      wait_cnt_q     <= 8'd0;
      rd_q           <= 5'd0;
      data_q         <= 32'd0;
      reg_write_q    <= 1'b0;
      instret_q      <= 64'd0;
      load_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      p_rd_q         <= p_rd_d;
      p_we_q         <= p_we_d;
      p_funct3_q     <= p_funct3_d;
      p_addr_lo_q    <= p_addr_lo_d;
      wait_cnt_q     <= wait_cnt_d;
      rd_q           <= rd_d;
      data_q         <= data_d;
      reg_write_q    <= reg_write_d;
      instret_q      <= instret_d;
      load_timeout_q <= load_timeout_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a 4-cycle load watchdog.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_rd;
  logic        m_reg_write;
  logic        m_is_load;
  logic [2:0]  m_funct3;
  logic [1:0]  m_addr_lo;
  logic [31:0] m_result;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  rd;
  logic [31:0] reg_data3;
  logic        reg_write;
  logic [63:0] instret;
  logic        load_timeout;
  logic [1:0]  dbg_state;

  int          checks;
  int          errors;
  logic [63:0] exp_instret;

  wb_stage #(.TIMEOUT(8'd4)) dut (
    .CLK(clk), .RST(rst),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_reg_write(m_reg_write),
    .m_is_load(m_is_load), .m_funct3(m_funct3), .m_addr_lo(m_addr_lo), .m_result(m_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd(rd), .reg_data3(reg_data3), .reg_write(reg_write), .instret(instret),
    .load_timeout(load_timeout), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_valid = 1'b0; m_rd = 5'd0; m_reg_write = 1'b0; m_is_load = 1'b0;
    m_funct3 = 3'd0; m_addr_lo = 2'd0; m_result = 32'd0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    step(); step();
    rst = 1'b0;
    exp_instret = 64'd0;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", m_ready); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", reg_write); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0d exp 0", instret); end
    checks++; if ({rd, reg_data3, load_timeout, dbg_state} !== 40'd0)
      begin errors++; $display("FAIL reset_outs got rd=%0d data=%h to=%0b st=%0d exp zeros", rd, reg_data3, load_timeout, dbg_state); end
  endtask

  task automatic test_non_load();
    m_valid = 1'b1; m_rd = 5'd5; m_reg_write = 1'b1; m_is_load = 1'b0; m_result = 32'hDEADBEEF;
    step();
    m_valid = 1'b0;
    exp_instret = exp_instret + 64'd1;
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL nl_we got %0b exp 1", reg_write); end
    checks++; if (rd !== 5'd5) begin errors++; $display("FAIL nl_rd got %0d exp 5", rd); end
    checks++; if (reg_data3 !== 32'hDEADBEEF) begin errors++; $display("FAIL nl_data got %h exp deadbeef", reg_data3); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL nl_instret got %0d exp %0d", instret, exp_instret); end
    step();
    checks++; if (reg_write !== 1'b0 || dbg_state !== 2'd0)
      begin errors++; $display("FAIL nl_idle got we=%0b st=%0d exp we=0 st=0", reg_write, dbg_state); end
    checks++; if (rd !== 5'd5 || reg_data3 !== 32'hDEADBEEF)
      begin errors++; $display("FAIL nl_hold got rd=%0d data=%h exp 5 deadbeef", rd, reg_data3); end
  endtask

  task automatic test_load();
    logic [4:0]  t_rd[5]    = '{5'd7, 5'd9, 5'd10, 5'd11, 5'd0};
    logic [2:0]  t_f3[5]    = '{3'b000, 3'b101, 3'b010, 3'b001, 3'b100};
    logic [1:0]  t_addr[5]  = '{2'd3, 2'd2, 2'd1, 2'd1, 2'd1};
    logic [31:0] t_rdata[5] = '{32'h80123456, 32'h80123456, 32'h12345678, 32'h0000F00D, 32'h0000AB00};
    int          t_dly[5]   = '{4, 1, 2, 1, 3};
    logic [31:0] t_exp[5]   = '{32'hFFFFFF80, 32'h00008012, 32'h12345678, 32'hFFFFF00D, 32'h000000AB};
    for (int i = 0; i < 5; i++) begin
      m_valid = 1'b1; m_is_load = 1'b1; m_reg_write = 1'b1; m_rd = t_rd[i];
      m_funct3 = t_f3[i]; m_addr_lo = t_addr[i]; m_result = 32'h55555555;
      step();
      m_valid = 1'b0; m_is_load = 1'b0;
      for (int c = 1; c <= t_dly[i]; c++) begin
        checks++; if (m_ready !== 1'b0 || reg_write !== 1'b0)
          begin errors++; $display("FAIL ld%0d_wait%0d got ready=%0b we=%0b exp 0 0", i, c, m_ready, reg_write); end
        if (c == t_dly[i]) begin dmem_rvalid = 1'b1; dmem_rdata = t_rdata[i]; end
        step();
      end
      dmem_rvalid = 1'b0;
      exp_instret = exp_instret + 64'd1;
      checks++; if (reg_data3 !== t_exp[i]) begin errors++; $display("FAIL ld%0d_data got %h exp %h", i, reg_data3, t_exp[i]); end
      checks++; if (reg_write !== (t_rd[i] != 5'd0) || rd !== t_rd[i])
        begin errors++; $display("FAIL ld%0d_we got we=%0b rd=%0d exp we=%0b rd=%0d", i, reg_write, rd, t_rd[i] != 5'd0, t_rd[i]); end
      checks++; if (instret !== exp_instret || m_ready !== 1'b1)
        begin errors++; $display("FAIL ld%0d_instret got %0d ready=%0b exp %0d 1", i, instret, m_ready, exp_instret); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] r;
    m_valid = 1'b1; m_is_load = 1'b0; m_reg_write = 1'b1;
    for (int i = 0; i < 9; i++) begin
      r = (i < 8) ? 5'(i + 1) : 5'd0;
      m_rd = r; m_result = 32'h10000000 + 32'(i);
      step();
      exp_instret = exp_instret + 64'd1;
      checks++; if (reg_write !== (r != 5'd0) || rd !== r || reg_data3 !== 32'h10000000 + 32'(i))
        begin errors++; $display("FAIL b2b%0d got we=%0b rd=%0d data=%h exp we=%0b rd=%0d data=%h",
          i, reg_write, rd, reg_data3, r != 5'd0, r, 32'h10000000 + 32'(i)); end
      checks++; if (instret !== exp_instret || m_ready !== 1'b1)
        begin errors++; $display("FAIL b2b%0d_instret got %0d ready=%0b exp %0d 1", i, instret, m_ready, exp_instret); end
    end
    m_valid = 1'b0;
    step();
    checks++; if (reg_write !== 1'b0 || dbg_state !== 2'd0)
      begin errors++; $display("FAIL b2b_idle got we=%0b st=%0d exp 0 0", reg_write, dbg_state); end
  endtask

  task automatic test_timeout();
    m_valid = 1'b1; m_is_load = 1'b1; m_reg_write = 1'b1; m_rd = 5'd3; m_funct3 = 3'b010; m_addr_lo = 2'd0;
    step();
    m_valid = 1'b0; m_is_load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (m_ready !== 1'b0 || load_timeout !== 1'b0)
        begin errors++; $display("FAIL to_wait%0d got ready=%0b to=%0b exp 0 0", c, m_ready, load_timeout); end
      step();
    end
    checks++; if (load_timeout !== 1'b1 || m_ready !== 1'b1 || reg_write !== 1'b0)
      begin errors++; $display("FAIL to_flag got to=%0b ready=%0b we=%0b exp 1 1 0", load_timeout, m_ready, reg_write); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL to_instret got %0d exp %0d", instret, exp_instret); end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    step();
    dmem_rvalid = 1'b0;
    checks++; if (reg_write !== 1'b0 || dbg_state !== 2'd0 || instret !== exp_instret || reg_data3 === 32'hCAFEF00D)
      begin errors++; $display("FAIL to_stray got we=%0b st=%0d instret=%0d data=%h exp 0 0 %0d", reg_write, dbg_state, instret, reg_data3, exp_instret); end
    m_valid = 1'b1; m_rd = 5'd4; m_result = 32'h00000044;
    step();
    m_valid = 1'b0;
    exp_instret = exp_instret + 64'd1;
    checks++; if (load_timeout !== 1'b1 || reg_write !== 1'b1 || instret !== exp_instret)
      begin errors++; $display("FAIL to_sticky got to=%0b we=%0b instret=%0d exp 1 1 %0d", load_timeout, reg_write, instret, exp_instret); end
  endtask

  task automatic test_reset_in_wait();
    step();
    m_valid = 1'b1; m_is_load = 1'b1; m_reg_write = 1'b1; m_rd = 5'd6; m_funct3 = 3'b010;
    step();
    m_valid = 1'b0; m_is_load = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h12121212;
    step();
    dmem_rvalid = 1'b0;
    checks++; if (reg_write !== 1'b0 || instret !== 64'd0)
      begin errors++; $display("FAIL rw_we got we=%0b instret=%0d exp 0 0", reg_write, instret); end
    checks++; if ({rd, reg_data3, load_timeout, dbg_state} !== 40'd0 || m_ready !== 1'b1)
      begin errors++; $display("FAIL rw_outs got rd=%0d data=%h to=%0b st=%0d ready=%0b exp zeros ready=1",
        rd, reg_data3, load_timeout, dbg_state, m_ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_non_load();
    test_load();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
